glitch_sequencer: RTL and testbench

- Timing controller for the glitch output path.
- Holds glitch configuration written by the UART command decoder: pulse width, pulse count, trigger delay and inter-pulse gap.
- When armed, waits for a rising edge on the target trigger, then emits the programmed pulse train on glitch_out and returns to idle (one-shot).
- Sits between the command decoder and the glitch output pin.

---
 rtl/glitch_pkg.sv | 33 +++
 rtl/trig_edge.sv | 41 ++++
 rtl/glitch_sequencer.sv | 158 +++++++++++++++
 tb/tb_glitch_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
// glitch_pkg: command codes, FSM states and config
// reset defaults shared by the sequencer and decoder.
package glitch_pkg;

  localparam logic [7:0] CMD_WIDTH    = 8'h10;
  localparam logic [7:0] CMD_COUNT    = 8'h11;
  localparam logic [7:0] CMD_DELAY_LO = 8'h12;
  localparam logic [7:0] CMD_DELAY_HI = 8'h13;
  localparam logic [7:0] CMD_GAP      = 8'h14;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  localparam logic [7:0]  RST_WIDTH = 8'd1;
  localparam logic [7:0]  RST_COUNT = 8'd1;
  localparam logic [15:0] RST_DELAY = 16'd0;
  localparam logic [7:0]  RST_GAP   = 8'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  // a zero width or gap still lasts one cycle
  function automatic logic [7:0] min1(
    input logic [7:0] v
  );
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/trig_edge.sv
// trig_edge: rising-edge detector on the target trigger.
// GLITCH_TRIG_SYNC_EN adds a 2-flop synchronizer in front.
module trig_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_trig,
  output logic o_rise
);

  logic w_trig;
  logic r_prev;

`ifdef GLITCH_TRIG_SYNC_EN
  logic r_s1;
  logic r_s2;

  // two-flop synchronizer for an asynchronous trigger
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_trig;
      r_s2 <= r_s1;
    end
  end

  assign w_trig = r_s2;
`else
  assign w_trig = i_trig;
`endif

  // previous sample, refreshed every cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= 1'b0;
    else       r_prev <= w_trig;
  end

  assign o_rise = w_trig & ~r_prev;

endmodule

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: config registers and one-shot pulse
// train FSM. Optional macro: GLITCH_TRIG_SYNC_EN.
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_sel,
  input  logic [7:0] cfg_data,
  input  logic       arm,
  input  logic       abort,
  input  logic       trigger,
  output logic       glitch_out,
  output logic       busy,
  output logic       done
);

  state_t r_state;
  state_t w_next;

  logic [7:0]       r_width;
  logic [7:0]       r_count;
  logic [CNT_W-1:0] r_delay;
  logic [7:0]       r_gap;

  logic [CNT_W-1:0] r_dly_c;
  logic [7:0]       r_wid_c;
  logic [7:0]       r_gap_c;
  logic [7:0]       r_cnt_c;
  logic [7:0]       r_sw;
  logic [7:0]       r_sg;

  logic r_glitch;
  logic r_done;
  logic w_rise;

  trig_edge u_edge (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_trig (trigger),
    .o_rise (w_rise)
  );

  // config registers, writable in any state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_width <= RST_WIDTH;
      r_count <= RST_COUNT;
      r_delay <= CNT_W'(RST_DELAY);
      r_gap   <= RST_GAP;
    end else if (cfg_wr) begin
      unique case (1'b1)
        (cfg_sel == CMD_WIDTH):    r_width <= cfg_data;
        (cfg_sel == CMD_COUNT):    r_count <= cfg_data;
        (cfg_sel == CMD_DELAY_LO): r_delay[7:0] <= cfg_data;
        (cfg_sel == CMD_DELAY_HI): r_delay[15:8] <= cfg_data;
        (cfg_sel == CMD_GAP):      r_gap <= cfg_data;
        default: ;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next-state logic; abort overrides everything
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (arm) w_next = S_ARMED;
      S_ARMED: begin
        if (w_rise) begin
          if (r_count == 8'd0)  w_next = S_DONE;
          else if (r_delay == '0) w_next = S_PULSE;
          else                    w_next = S_DELAY;
        end
      end
      S_DELAY:
        if (r_dly_c <= CNT_W'(1)) w_next = S_PULSE;
      S_PULSE: begin
        if (r_wid_c <= 8'd1) begin
          if (r_cnt_c <= 8'd1) w_next = S_DONE;
          else                 w_next = S_GAP;
        end
      end
      S_GAP:
        if (r_gap_c <= 8'd1) w_next = S_PULSE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // working counters: snapshot on the edge, then
  // count down to 1 and hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dly_c <= '0;
      r_wid_c <= 8'd0;
      r_gap_c <= 8'd0;
      r_cnt_c <= 8'd0;
      r_sw    <= 8'd0;
      r_sg    <= 8'd0;
    end else begin
      unique case (r_state)
        S_ARMED: begin
          if (w_rise) begin
            r_dly_c <= r_delay;
            r_cnt_c <= r_count;
            r_wid_c <= min1(r_width);
            r_sw    <= min1(r_width);
            r_sg    <= min1(r_gap);
          end
        end
        S_DELAY: begin
          if (r_dly_c > CNT_W'(1))
            r_dly_c <= r_dly_c - CNT_W'(1);
        end
        S_PULSE: begin
          if (r_wid_c > 8'd1) begin
            r_wid_c <= r_wid_c - 8'd1;
          end else begin
            r_gap_c <= r_sg;
            if (r_cnt_c != 8'd0)
              r_cnt_c <= r_cnt_c - 8'd1;
          end
        end
        S_GAP: begin
          if (r_gap_c > 8'd1) r_gap_c <= r_gap_c - 8'd1;
          else                r_wid_c <= r_sw;
        end
        default: ;
      endcase
    end
  end

  // registered outputs track the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_glitch <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_glitch <= (w_next == S_PULSE);
      r_done   <= (w_next == S_DONE);
    end
  end

  assign glitch_out = r_glitch;
  assign done       = r_done;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb_glitch_sequencer: directed vectors for the glitch
// sequencer, with hand-computed timing per scenario.
module tb_glitch_sequencer;
  import glitch_pkg::*;

`ifdef GLITCH_TRIG_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       rst;
  logic       cfg_wr;
  logic [7:0] cfg_sel;
  logic [7:0] cfg_data;
  logic       arm;
  logic       abort;
  logic       trigger;
  logic       glitch_out;
  logic       busy;
  logic       done;

  int n_vec;
  int n_err;

  int f_rise, f_done, f_ndone, f_nrun;
  int f_gap, f_idle, f_cur;
  int f_run[4];
  int hits;

  glitch_sequencer #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_wr     (cfg_wr),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .arm        (arm),
    .abort      (abort),
    .trigger    (trigger),
    .glitch_out (glitch_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input int    obs,
    input int    exp
  );
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(
    input logic [7:0] sel,
    input logic [7:0] dat
  );
    cfg_sel  = sel;
    cfg_data = dat;
    cfg_wr   = 1'b1;
    step(1);
    cfg_wr   = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  // raise trigger and trace the run until busy drops
  task automatic fire(
    input int         budget,
    input int         wr_at,
    input logic [7:0] wsel,
    input logic [7:0] wdat
  );
    logic pg;
    int   lo;
    f_rise = 0; f_done = 0; f_ndone = 0;
    f_nrun = 0; f_gap = 0; f_idle = 0;
    f_cur = 0; lo = 0; pg = 1'b0;
    for (int k = 0; k < 4; k++) f_run[k] = 0;
    trigger = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      if (i == 3) trigger = 1'b0;
      if (i == wr_at) begin
        cfg_sel  = wsel;
        cfg_data = wdat;
        cfg_wr   = 1'b1;
      end else begin
        cfg_wr = 1'b0;
      end
      @(posedge clk);
      #1;
      if (glitch_out) begin
        if (!pg) begin
          if (f_rise == 0) f_rise = i;
          if (f_nrun == 1 && f_gap == 0) f_gap = lo;
        end
        f_cur++;
      end else begin
        if (pg) begin
          if (f_nrun < 4) f_run[f_nrun] = f_cur;
          f_nrun++;
          f_cur = 0;
          lo = 0;
        end
        lo++;
      end
      pg = glitch_out;
      if (done) begin
        f_ndone++;
        f_done = i;
      end
      if (!busy) begin
        f_idle = i;
        break;
      end
    end
    cfg_wr  = 1'b0;
    trigger = 1'b0;
    chk("run_ends", (f_idle > 0) ? 1 : 0, 1);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; cfg_wr = 1'b0;
    cfg_sel = 8'h00; cfg_data = 8'h00;
    arm = 1'b0; abort = 1'b0; trigger = 1'b0;
    step(3);
    chk("rst_glitch", glitch_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    step(2);

    // default config: single 1-cycle pulse
    do_arm();
    chk("dflt_armed", busy, 1);
    fire(20, 0, 8'h00, 8'h00);
    chk("dflt_rise", f_rise, 1 + LAT);
    chk("dflt_nrun", f_nrun, 1);
    chk("dflt_w", f_run[0], 1);
    chk("dflt_done", f_done, 2 + LAT);
    chk("dflt_ndone", f_ndone, 1);
    chk("dflt_idle", f_idle, 3 + LAT);

    // multi-pulse train, delay 0x0105
    wr(CMD_WIDTH, 8'd3);
    wr(CMD_COUNT, 8'd2);
    wr(CMD_GAP, 8'd4);
    wr(CMD_DELAY_LO, 8'h05);
    wr(CMD_DELAY_HI, 8'h01);
    do_arm();
    fire(400, 0, 8'h00, 8'h00);
    chk("multi_rise", f_rise, 262 + LAT);
    chk("multi_w0", f_run[0], 3);
    chk("multi_gap", f_gap, 4);
    chk("multi_w1", f_run[1], 3);
    chk("multi_nrun", f_nrun, 2);
    chk("multi_done", f_done, 272 + LAT);
    chk("multi_idle", f_idle, 273 + LAT);

    // count=0: no pulse, done next cycle
    wr(CMD_COUNT, 8'd0);
    do_arm();
    fire(20, 0, 8'h00, 8'h00);
    chk("c0_rise", f_rise, 0);
    chk("c0_nrun", f_nrun, 0);
    chk("c0_done", f_done, 1 + LAT);
    chk("c0_ndone", f_ndone, 1);

    // reset restores defaults; unknown codes ignored
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    wr(CMD_RESET, 8'h00);
    wr(8'h15, 8'h00);

    // stale trigger level does not fire
    trigger = 1'b1;
    step(4);
    do_arm();
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (glitch_out || done) hits++;
    end
    chk("stale_hits", hits, 0);
    chk("stale_armed", busy, 1);
    trigger = 1'b0;
    step(4);
    fire(20, 0, 8'h00, 8'h00);
    chk("stale_rise", f_rise, 1 + LAT);
    chk("stale_w", f_run[0], 1);
    chk("stale_done", f_done, 2 + LAT);

    // arm in the same cycle as the detected edge
    step(4);
    trigger = 1'b1;
    step(LAT);
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (glitch_out || done) hits++;
    end
    chk("same_hits", hits, 0);
    chk("same_armed", busy, 1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_armed", busy, 0);
    trigger = 1'b0;
    step(4);

    // abort (with arm) mid-PULSE
    wr(CMD_WIDTH, 8'd50);
    do_arm();
    trigger = 1'b1;
    step(6 + LAT);
    trigger = 1'b0;
    chk("ab_pre", glitch_out, 1);
    abort = 1'b1;
    arm   = 1'b1;
    step(1);
    abort = 1'b0;
    arm   = 1'b0;
    chk("ab_glitch", glitch_out, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (done || busy || glitch_out) hits++;
    end
    chk("ab_quiet", hits, 0);
    do_arm();
    fire(100, 0, 8'h00, 8'h00);
    chk("ab2_rise", f_rise, 1 + LAT);
    chk("ab2_w", f_run[0], 50);
    chk("ab2_done", f_done, 51 + LAT);

    // rst mid-PULSE
    do_arm();
    trigger = 1'b1;
    step(4 + LAT);
    trigger = 1'b0;
    chk("rm_pre", glitch_out, 1);
    rst = 1'b1;
    step(1);
    chk("rm_glitch", glitch_out, 0);
    chk("rm_busy", busy, 0);
    rst = 1'b0;
    step(3);
    do_arm();
    fire(20, 0, 8'h00, 8'h00);
    chk("rm_dflt_w", f_run[0], 1);
    chk("rm_dflt_done", f_done, 2 + LAT);

    // width write during DELAY affects next run only
    wr(CMD_WIDTH, 8'd2);
    wr(CMD_DELAY_LO, 8'd10);
    do_arm();
    fire(60, 6, CMD_WIDTH, 8'd9);
    chk("mw_rise", f_rise, 11 + LAT);
    chk("mw_w", f_run[0], 2);
    chk("mw_done", f_done, 13 + LAT);
    do_arm();
    fire(60, 0, 8'h00, 8'h00);
    chk("mw2_rise", f_rise, 11 + LAT);
    chk("mw2_w", f_run[0], 9);
    chk("mw2_done", f_done, 20 + LAT);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
